// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_S AXI-Stream masters share one slave, one packet at a time.
// Optional stall watchdog enabled by defining AXIS_ARB_TIMEOUT_EN (revokes a grant after TIMEOUT idle cycles).
module axis_rr_arbiter #(
  parameter int NUM_S   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_S-1:0]          s_tvalid,
  output logic [NUM_S-1:0]          s_tready,
  input  logic [NUM_S-1:0]          s_tlast,
  input  logic [NUM_S*DATA_W-1:0]   s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [NUM_S-1:0]          grant,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IDX_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] last_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic [NUM_S-1:0] grant_nxt;
  logic             busy_nxt;
  logic             lock;
  logic             owner_valid;
  logic             owner_last;
  logic             accept;
  logic             stall_expire;

  assign lock        = (state == LOCK);
  assign owner_valid = s_tvalid[owner];
  assign owner_last  = s_tlast[owner];

  // Pass-through path: outputs follow the owner combinationally, gated by the registered state
  assign m_tvalid = lock & owner_valid;
  assign m_tlast  = lock & owner_last;
  assign m_tdata  = s_tdata[owner*DATA_W +: DATA_W];
  assign s_tready = grant & {NUM_S{lock & m_tready}};
  assign accept   = m_tvalid & m_tready;

  // Scan downward so the candidate closest to last_ptr+1 is written last and wins
  always_comb begin
    pick_idx = last_ptr;
    cand     = '0;
    for (int i = NUM_S; i >= 1; i--) begin
      cand = IDX_W'((int'(last_ptr) + i) % NUM_S);
      if (s_tvalid[cand]) begin
        pick_idx = cand;
      end
    end
  end

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;
  logic             timeout_q;

  // Only owner-side silence counts; slave backpressure leaves owner_valid high and clears the count
  assign stall_expire = lock && !owner_valid && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    stall_cnt_nxt = '0;
    if (lock && !owner_valid && !stall_expire) begin
      stall_cnt_nxt = stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      timeout_q <= stall_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_expire = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_ptr;
    grant_nxt = grant;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (|s_tvalid) begin
          owner_nxt = pick_idx;
          grant_nxt = NUM_S'(1) << pick_idx;
          busy_nxt  = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if ((accept && owner_last) || stall_expire) begin
          last_nxt  = owner;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset points last_ptr at the highest input so input 0 is favoured first
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      owner    <= '0;
      last_ptr <= IDX_W'(NUM_S - 1);
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_ptr <= last_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: vector table plus hand sequences for RR order, backpressure, stall and reset.
module tb_axis_rr_arbiter;

  logic         aclk;
  logic         areset;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [127:0] s_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   grant;
  logic         busy;
  logic         timeout;

  int total;
  int bad;
  int bc[4];

  axis_rr_arbiter #(.NUM_S(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0]   v;
    logic [3:0]   l;
    logic [127:0] d;
    logic         rdy;
    logic [3:0]   g;
    logic         b;
    logic         mv;
    logic [31:0]  md;
    logic         ml;
    logic [3:0]   sr;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [127:0] d, input logic rdy);
    s_tvalid = v;
    s_tlast  = l;
    s_tdata  = d;
    m_tready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Compares all outputs at the negedge, then advances to just after the next posedge
  task automatic checkCycle(input string name, input logic [3:0] g, input logic b,
                            input logic mv, input logic [31:0] md, input logic ml,
                            input logic [3:0] sr, input logic to);
    @(negedge aclk);
    checkOutput({name, ".grant"}, 64'(grant), 64'(g));
    checkOutput({name, ".busy"}, 64'(busy), 64'(b));
    checkOutput({name, ".m_tvalid"}, 64'(m_tvalid), 64'(mv));
    checkOutput({name, ".m_tlast"}, 64'(m_tlast), 64'(ml));
    checkOutput({name, ".s_tready"}, 64'(s_tready), 64'(sr));
    checkOutput({name, ".timeout"}, 64'(timeout), 64'(to));
    if (mv) checkOutput({name, ".m_tdata"}, 64'(m_tdata), 64'(md));
    @(posedge aclk);
    #1;
  endtask

  task automatic doReset(input string name);
    areset = 1'b1;
    applyStimulus(4'b1111, 4'b0000, '0, 1'b1);
    @(negedge aclk);
    checkOutput({name, ".rst_grant"}, 64'(grant), 64'd0);
    checkOutput({name, ".rst_busy"}, 64'(busy), 64'd0);
    checkOutput({name, ".rst_m_tvalid"}, 64'(m_tvalid), 64'd0);
    checkOutput({name, ".rst_s_tready"}, 64'(s_tready), 64'd0);
    checkOutput({name, ".rst_timeout"}, 64'(timeout), 64'd0);
    areset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  task automatic driveRr();
    logic [127:0] d;
    logic [3:0]   l;
    d = '0;
    l = '0;
    for (int i = 0; i < 4; i++) begin
      d[i*32 +: 32] = 32'h100 * i + bc[i];
      l[i]          = (bc[i] == 1);
    end
    applyStimulus(4'b1111, l, d, 1'b1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    areset   = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;

    // {v, l, d={m3,m2,m1,m0}, rdy, grant, busy, m_tvalid, m_tdata, m_tlast, s_tready}
    vecs[0]  = '{4'b0001, 4'b0000, {96'h0, 32'hA0}, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 4'b0000};
    vecs[1]  = '{4'b0001, 4'b0000, {96'h0, 32'hA0}, 1'b1, 4'b0001, 1'b1, 1'b1, 32'hA0, 1'b0, 4'b0001};
    vecs[2]  = '{4'b0001, 4'b0000, {96'h0, 32'hA1}, 1'b1, 4'b0001, 1'b1, 1'b1, 32'hA1, 1'b0, 4'b0001};
    vecs[3]  = '{4'b0001, 4'b0001, {96'h0, 32'hA2}, 1'b1, 4'b0001, 1'b1, 1'b1, 32'hA2, 1'b1, 4'b0001};
    vecs[4]  = '{4'b0000, 4'b0000, 128'h0,          1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 4'b0000};
    vecs[5]  = '{4'b0010, 4'b0010, {64'h0, 32'hB1, 32'h0}, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0010, 4'b0010, {64'h0, 32'hB1, 32'h0}, 1'b1, 4'b0010, 1'b1, 1'b1, 32'hB1, 1'b1, 4'b0010};
    vecs[7]  = '{4'b1010, 4'b1000, {32'hC3, 32'h0, 32'hB1, 32'h0}, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b1011, 4'b1000, {32'hC3, 32'h0, 32'hB1, 32'hA5}, 1'b1, 4'b1000, 1'b1, 1'b1, 32'hC3, 1'b1, 4'b1000};
    vecs[9]  = '{4'b0011, 4'b0000, {32'h0, 32'h0, 32'hB1, 32'hA5}, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
    vecs[10] = '{4'b0011, 4'b0001, {32'h0, 32'h0, 32'hB1, 32'hA5}, 1'b1, 4'b0001, 1'b1, 1'b1, 32'hA5, 1'b1, 4'b0001};
    vecs[11] = '{4'b0010, 4'b0010, {64'h0, 32'hB1, 32'h0}, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
    vecs[12] = '{4'b0010, 4'b0010, {64'h0, 32'hB1, 32'h0}, 1'b1, 4'b0010, 1'b1, 1'b1, 32'hB1, 1'b1, 4'b0010};
    vecs[13] = '{4'b0000, 4'b0000, 128'h0,          1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 4'b0000};

    #2;
    doReset("init");
    $display("[TB] vector table");
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k].v, vecs[k].l, vecs[k].d, vecs[k].rdy);
      checkCycle($sformatf("vec%0d", k), vecs[k].g, vecs[k].b, vecs[k].mv,
                 vecs[k].md, vecs[k].ml, vecs[k].sr, 1'b0);
    end

    $display("[TB] round robin, all masters, 2-beat packets");
    doReset("rr");
    for (int i = 0; i < 4; i++) bc[i] = 0;
    for (int p = 0; p < 8; p++) begin
      int owner;
      owner = p % 4;
      driveRr();
      checkCycle($sformatf("rr%0d_bubble", p), 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
      for (int beat = 0; beat < 2; beat++) begin
        driveRr();
        checkCycle($sformatf("rr%0d_b%0d", p, beat), 4'(1 << owner), 1'b1, 1'b1,
                   32'h100 * owner + beat, (beat == 1), 4'(1 << owner), 1'b0);
        bc[owner] = (bc[owner] + 1) % 2;
      end
    end

    $display("[TB] slave backpressure");
    doReset("bp");
    applyStimulus(4'b0100, 4'b0000, {32'h0, 32'hD0, 64'h0}, 1'b1);
    checkCycle("bp_idle", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
    checkCycle("bp_b0", 4'b0100, 1'b1, 1'b1, 32'hD0, 1'b0, 4'b0100, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0100, 4'b0000, {32'h0, 32'hD1, 64'h0}, 1'b0);
      checkCycle($sformatf("bp_hold%0d", c), 4'b0100, 1'b1, 1'b1, 32'hD1, 1'b0, 4'b0000, 1'b0);
    end
    applyStimulus(4'b0100, 4'b0000, {32'h0, 32'hD1, 64'h0}, 1'b1);
    checkCycle("bp_b1", 4'b0100, 1'b1, 1'b1, 32'hD1, 1'b0, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 4'b0100, {32'h0, 32'hD2, 64'h0}, 1'b1);
    checkCycle("bp_b2", 4'b0100, 1'b1, 1'b1, 32'hD2, 1'b1, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 128'h0, 1'b1);
    checkCycle("bp_done", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);

    $display("[TB] owner stall");
    doReset("st");
    applyStimulus(4'b0001, 4'b0000, {96'h0, 32'hE0}, 1'b1);
    checkCycle("st_idle", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
    checkCycle("st_b0", 4'b0001, 1'b1, 1'b1, 32'hE0, 1'b0, 4'b0001, 1'b0);
    applyStimulus(4'b0010, 4'b0010, {64'h0, 32'hE1, 32'h0}, 1'b1);
`ifdef AXIS_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      checkCycle($sformatf("st_wait%0d", c), 4'b0001, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0001, 1'b0);
    end
    checkCycle("st_revoke", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b1);
    checkCycle("st_next", 4'b0010, 1'b1, 1'b1, 32'hE1, 1'b1, 4'b0010, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 128'h0, 1'b1);
    checkCycle("st_done", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      checkCycle($sformatf("st_hold%0d", c), 4'b0001, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0001, 1'b0);
    end
`endif

    $display("[TB] reset mid-packet");
    doReset("mr");
    applyStimulus(4'b0001, 4'b0000, {96'h0, 32'hF0}, 1'b1);
    checkCycle("mr_idle", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
    @(negedge aclk);
    checkOutput("mr_pre.m_tvalid", 64'(m_tvalid), 64'd1);
    checkOutput("mr_pre.grant", 64'(grant), 64'b0001);
    areset = 1'b1;
    #1;
    checkOutput("mr_rst.grant", 64'(grant), 64'd0);
    checkOutput("mr_rst.busy", 64'(busy), 64'd0);
    checkOutput("mr_rst.m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("mr_rst.s_tready", 64'(s_tready), 64'd0);
    #2;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checkCycle("mr_after", 4'b0001, 1'b1, 1'b1, 32'hF0, 1'b0, 4'b0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
